// File: rtl/rpsc_power_sequencer.sv
// RPSC power sequencer: brings N supply stages up in order behind debounced ready feedback,
// shuts them down in reverse, and latches timeout / drop-out faults.
module rpsc_power_sequencer #(
  parameter int N_STAGES     = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int TIMEOUT_CYC  = 1000,
  parameter int SHUT_GAP     = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                on_cmd,
  input  logic                fault_clr,
  input  logic [N_STAGES-1:0] ready_n,
  input  logic                rf_req_n,
  output logic [N_STAGES-1:0] en_n,
  output logic                sb_on_n,
  output logic                rf_perm_n,
  output logic                fault,
  output logic [2:0]          fault_stage,
  output logic [2:0]          state
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(SHUT_GAP + 1);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYC);
  localparam logic [GW-1:0] G_LAST = GW'(SHUT_GAP - 1);
  localparam logic [GW-1:0] G_MAX  = GW'(SHUT_GAP);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [2:0]    TOP    = 3'(N_STAGES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAMP  = 3'd1,
    RUN   = 3'd2,
    SHUT  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t                st;
  logic [2:0]            stg;
  logic [TW-1:0]         timer;
  logic [GW-1:0]         gap;
  logic [N_STAGES-1:0]   rdy_s1, rdy_s2, rdy;
  logic                  rf_s1, rf_s2;
  logic [DW-1:0]         db_cnt [N_STAGES];
  logic [N_STAGES-1:0]   ramp_drop, run_drop;
  logic                  cur_rdy;

  function automatic logic [N_STAGES-1:0] bit_of(input logic [2:0] s);
    return N_STAGES'(1) << s;
  endfunction

  function automatic logic [2:0] lowest(input logic [N_STAGES-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = N_STAGES - 1; i >= 0; i--)
      if (v[i]) idx = 3'(i);
    return idx;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_s1 <= '1;
      rdy_s2 <= '1;
      rf_s1  <= 1'b1;
      rf_s2  <= 1'b1;
    end else begin
      rdy_s1 <= ready_n;
      rdy_s2 <= rdy_s1;
      rf_s1  <= rf_req_n;
      rf_s2  <= rf_s1;
    end
  end

  // rdy is the inverse of the synced level, so a sample "differs" when s2 equals rdy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy <= '0;
      for (int i = 0; i < N_STAGES; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_STAGES; i++) begin
        if (rdy_s2[i] == rdy[i]) begin
          if (db_cnt[i] >= D_LAST) begin
            rdy[i]    <= ~rdy_s2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    ramp_drop = ~rdy & (bit_of(stg) - N_STAGES'(1));
    run_drop  = ~rdy;
    cur_rdy   = |(rdy & bit_of(stg));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= IDLE;
      stg         <= '0;
      timer       <= '0;
      gap         <= '0;
      en_n        <= '1;
      sb_on_n     <= 1'b1;
      rf_perm_n   <= 1'b1;
      fault       <= 1'b0;
      fault_stage <= '0;
    end else begin
      case (st)
        IDLE: begin
          en_n <= '1;
          if (on_cmd && !fault) begin
            st    <= RAMP;
            stg   <= '0;
            en_n  <= ~bit_of(3'd0);
            timer <= '0;
          end
        end
        // A drop-out always involves a stage below stg, so it wins over a same-cycle timeout
        RAMP: begin
          if (|ramp_drop) begin
            st          <= FAULT;
            fault       <= 1'b1;
            fault_stage <= lowest(ramp_drop);
            en_n        <= '1;
          end else if (!cur_rdy && timer == T_LAST) begin
            st          <= FAULT;
            fault       <= 1'b1;
            fault_stage <= stg;
            en_n        <= '1;
          end else if (!on_cmd) begin
            st   <= SHUT;
            en_n <= en_n | bit_of(stg);
            gap  <= '0;
          end else if (cur_rdy) begin
            if (stg == TOP) begin
              st      <= RUN;
              sb_on_n <= 1'b0;
            end else begin
              stg   <= stg + 3'd1;
              en_n  <= en_n & ~bit_of(stg + 3'd1);
              timer <= '0;
            end
          end else if (timer != T_MAX) begin
            timer <= timer + 1'b1;
          end
        end
        RUN: begin
          if (|run_drop) begin
            st          <= FAULT;
            fault       <= 1'b1;
            fault_stage <= lowest(run_drop);
            en_n        <= '1;
            sb_on_n     <= 1'b1;
            rf_perm_n   <= 1'b1;
          end else if (!on_cmd) begin
            st        <= SHUT;
            en_n      <= en_n | bit_of(stg);
            gap       <= '0;
            sb_on_n   <= 1'b1;
            rf_perm_n <= 1'b1;
          end else begin
            rf_perm_n <= rf_s2;
          end
        end
        // stg tracks the most recently disabled stage while walking back down
        SHUT: begin
          if (en_n[0]) begin
            st    <= IDLE;
            stg   <= '0;
            gap   <= '0;
            timer <= '0;
          end else if (gap == G_LAST) begin
            stg  <= stg - 3'd1;
            en_n <= en_n | bit_of(stg - 3'd1);
            gap  <= '0;
          end else if (gap != G_MAX) begin
            gap <= gap + 1'b1;
          end
        end
        FAULT: begin
          en_n      <= '1;
          fault     <= 1'b1;
          sb_on_n   <= 1'b1;
          rf_perm_n <= 1'b1;
          if (fault_clr && !on_cmd) begin
            st          <= IDLE;
            fault       <= 1'b0;
            fault_stage <= '0;
            stg         <= '0;
            timer       <= '0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_rpsc_power_sequencer.sv
// Scoreboard bench for rpsc_power_sequencer: expected output snapshots are queued ahead of
// stimulus and a negedge monitor checks each observed output change in order and timing.
module tb_rpsc_power_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       on_cmd = 1'b0;
  logic       fault_clr = 1'b0;
  logic [3:0] ready_n = 4'b1111;
  logic       rf_req_n = 1'b1;
  logic [3:0] en_n;
  logic       sb_on_n, rf_perm_n, fault;
  logic [2:0] fault_stage, state;

  logic [3:0] stuck = '0;
  logic [3:0] glitch = '0;
  int         rsp_cnt [4];
  int         tests = 0;
  int         failed = 0;
  int         cyc = 0;

  typedef struct {
    logic [12:0] outs;
    int          delta;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur_e;
  logic [12:0] last_snap;
  int          last_cyc = 0;
  logic [12:0] dut_snap;

  assign dut_snap = {state, en_n, sb_on_n, rf_perm_n, fault, fault_stage};

  rpsc_power_sequencer #(
    .N_STAGES(4), .DEBOUNCE_CYC(4), .TIMEOUT_CYC(50), .SHUT_GAP(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .on_cmd(on_cmd), .fault_clr(fault_clr),
    .ready_n(ready_n), .rf_req_n(rf_req_n), .en_n(en_n), .sb_on_n(sb_on_n),
    .rf_perm_n(rf_perm_n), .fault(fault), .fault_stage(fault_stage), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [12:0] snap(input logic [2:0] st, input logic [3:0] en,
                                       input logic sb, input logic rf, input logic f,
                                       input logic [2:0] fs);
    return {st, en, sb, rf, f, fs};
  endfunction

  function automatic void expectOut(input string name, input logic [12:0] o, input int d);
    exp_t e;
    e.outs  = o;
    e.delta = d;
    e.name  = name;
    exp_q.push_back(e);
  endfunction

  // Supply model: a stage reports ready (low) more than 10 cycles after its enable falls
  initial begin
    for (int i = 0; i < 4; i++) rsp_cnt[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (en_n[i]) rsp_cnt[i] = 0;
        else if (rsp_cnt[i] < 100) rsp_cnt[i]++;
        ready_n[i] = en_n[i] | stuck[i] | (rsp_cnt[i] <= 10) | glitch[i];
      end
    end
  end

  always @(negedge clk) begin
    if (dut_snap !== last_snap) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL unexpected_change: got %h, required no change from %h", dut_snap, last_snap);
      end else begin
        cur_e = exp_q.pop_front();
        tests++;
        if (dut_snap !== cur_e.outs) begin
          failed++;
          $display("[TB] FAIL %s: got %h, required %h", cur_e.name, dut_snap, cur_e.outs);
        end
        if (cur_e.delta >= 0) begin
          tests++;
          if (cyc - last_cyc != cur_e.delta) begin
            failed++;
            $display("[TB] FAIL %s_timing: got %0d cycles, required %0d", cur_e.name,
                     cyc - last_cyc, cur_e.delta);
          end
        end
      end
      last_snap = dut_snap;
      last_cyc  = cyc;
    end
  end

  task automatic applyStimulus(input logic on, input logic clr, input logic rfreq);
    @(negedge clk);
    on_cmd    = on;
    fault_clr = clr;
    rf_req_n  = rfreq;
  endtask

  task automatic checkOutput(input string name, input logic [12:0] req);
    tests++;
    if (dut_snap !== req) begin
      failed++;
      $display("[TB] FAIL %s: got %h, required %h", name, dut_snap, req);
    end
  endtask

  task automatic waitState(input logic [2:0] target, input int budget, input string name);
    int n;
    n = 0;
    while (state !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (state !== target) begin
      failed++;
      $display("[TB] FAIL %s: state %0d, required %0d", name, state, target);
    end
  endtask

  task automatic pulseReady(input int stage, input int len);
    glitch[stage] = 1'b1;
    repeat (len) @(negedge clk);
    glitch = '0;
  endtask

  task automatic expectRampUp();
    expectOut("ramp_s0", snap(3'd1, 4'b1110, 1'b1, 1'b1, 1'b0, 3'd0), -1);
    expectOut("ramp_s1", snap(3'd1, 4'b1100, 1'b1, 1'b1, 1'b0, 3'd0), 17);
    expectOut("ramp_s2", snap(3'd1, 4'b1000, 1'b1, 1'b1, 1'b0, 3'd0), 17);
    expectOut("ramp_s3", snap(3'd1, 4'b0000, 1'b1, 1'b1, 1'b0, 3'd0), 17);
    expectOut("run",     snap(3'd2, 4'b0000, 1'b0, 1'b1, 1'b0, 3'd0), 17);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    last_snap = snap(3'd0, 4'b1111, 1'b1, 1'b1, 1'b0, 3'd0);
    #1 rst_n = 1'b0;
    #2 checkOutput("reset_state", snap(3'd0, 4'b1111, 1'b1, 1'b1, 1'b0, 3'd0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Normal power-up
    expectRampUp();
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitState(3'd2, 200, "reach_run");
    repeat (5) @(negedge clk);

    // Short glitch is filtered, long one latches a stage-1 drop-out
    pulseReady(1, 3);
    repeat (15) @(negedge clk);
    checkOutput("glitch_short", snap(3'd2, 4'b0000, 1'b0, 1'b1, 1'b0, 3'd0));
    expectOut("dropout_fault", snap(3'd4, 4'b1111, 1'b1, 1'b1, 1'b1, 3'd1), -1);
    pulseReady(1, 6);
    waitState(3'd4, 30, "reach_dropout_fault");

    // Clear ignored while on_cmd=1, honoured with on_cmd=0
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("clr_ignored", snap(3'd4, 4'b1111, 1'b1, 1'b1, 1'b1, 3'd1));
    expectOut("clr_to_idle", snap(3'd0, 4'b1111, 1'b1, 1'b1, 1'b0, 3'd0), -1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitState(3'd0, 10, "clr_idle");
    repeat (10) @(negedge clk);

    // Stage 2 never reports ready
    stuck = 4'b0100;
    expectOut("to_ramp_s0", snap(3'd1, 4'b1110, 1'b1, 1'b1, 1'b0, 3'd0), -1);
    expectOut("to_ramp_s1", snap(3'd1, 4'b1100, 1'b1, 1'b1, 1'b0, 3'd0), 17);
    expectOut("to_ramp_s2", snap(3'd1, 4'b1000, 1'b1, 1'b1, 1'b0, 3'd0), 17);
    expectOut("timeout_fault", snap(3'd4, 4'b1111, 1'b1, 1'b1, 1'b1, 3'd2), 50);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitState(3'd4, 200, "reach_timeout_fault");
    @(negedge clk);
    checkOutput("timeout_hold", snap(3'd4, 4'b1111, 1'b1, 1'b1, 1'b1, 3'd2));
    stuck = '0;
    expectOut("timeout_clr", snap(3'd0, 4'b1111, 1'b1, 1'b1, 1'b0, 3'd0), -1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitState(3'd0, 10, "timeout_clr_idle");
    repeat (10) @(negedge clk);

    // Up again, RF permit, then reverse shutdown
    expectRampUp();
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitState(3'd2, 200, "reach_run2");
    repeat (5) @(negedge clk);
    expectOut("rf_permit", snap(3'd2, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0), -1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rf_not_yet", snap(3'd2, 4'b0000, 1'b0, 1'b1, 1'b0, 3'd0));
    @(negedge clk);
    checkOutput("rf_after_3", snap(3'd2, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0));
    expectOut("shut_3", snap(3'd3, 4'b1000, 1'b1, 1'b1, 1'b0, 3'd0), -1);
    expectOut("shut_2", snap(3'd3, 4'b1100, 1'b1, 1'b1, 1'b0, 3'd0), 8);
    expectOut("shut_1", snap(3'd3, 4'b1110, 1'b1, 1'b1, 1'b0, 3'd0), 8);
    expectOut("shut_0", snap(3'd3, 4'b1111, 1'b1, 1'b1, 1'b0, 3'd0), 8);
    expectOut("shut_idle", snap(3'd0, 4'b1111, 1'b1, 1'b1, 1'b0, 3'd0), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitState(3'd0, 60, "shut_done");
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);

    // Asynchronous reset in the middle of RAMP
    expectOut("rst_ramp_s0", snap(3'd1, 4'b1110, 1'b1, 1'b1, 1'b0, 3'd0), -1);
    expectOut("rst_ramp_s1", snap(3'd1, 4'b1100, 1'b1, 1'b1, 1'b0, 3'd0), 17);
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    expectOut("async_reset", snap(3'd0, 4'b1111, 1'b1, 1'b1, 1'b0, 3'd0), -1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset_now", snap(3'd0, 4'b1111, 1'b1, 1'b1, 1'b0, 3'd0));
    on_cmd = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
